// File: rtl/mem_readback_streamer_if.sv
// Bundle of the control, memory-read and output-stream signals of mem_readback_streamer.
//
// Handshake: a word moves on m_* when m_valid and m_ready are both high at a rising clk edge.
// While m_valid is high and m_ready is low, m_data/m_addr/m_last hold their values and m_valid
// stays high; m_valid never depends on m_ready.
interface mem_readback_streamer_if #(
    parameter int WID_MEM = 256,
    parameter int ADDR_W  = 7
);
    logic               start;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  mem_raddr;
    logic [WID_MEM-1:0] mem_rdata;
    logic               m_valid;
    logic               m_ready;
    logic [WID_MEM-1:0] m_data;
    logic [ADDR_W-1:0]  m_addr;
    logic               m_last;
    logic [WID_MEM-1:0] checksum;
    logic [1:0]         dbg_state;

    // Streamer side
    modport master (
        input  start, mem_rdata, m_ready,
        output busy, done, mem_raddr, m_valid, m_data, m_addr, m_last, checksum, dbg_state
    );

    // Controller / memory / downstream side
    modport slave (
        output start, mem_rdata, m_ready,
        input  busy, done, mem_raddr, m_valid, m_data, m_addr, m_last, checksum, dbg_state
    );
endinterface

// File: rtl/mem_readback_streamer.sv
// Sweeps every address of a block-RAM read port after a start pulse and streams the words out
// on a valid/ready interface with address and last tags, keeping a running XOR checksum.
// The memory is expected to present mem_rdata for mem_raddr in the cycle after mem_raddr is
// registered. A 2-entry FIFO absorbs the read latency so back-pressure never drops a word.
module mem_readback_streamer #(
    parameter int WID_MEM   = 256,
    parameter int DEPTH_MEM = 128,
    parameter int ADDR_W    = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_readback_streamer_if.master bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic               inflight_q, inflight_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WID_MEM-1:0] csum_q, csum_d;

    logic [WID_MEM-1:0] f_data_q [2];
    logic [ADDR_W-1:0]  f_addr_q [2];
    logic               f_last_q [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;

    logic               push;
    logic               pop;
    logic               issue;
    logic [1:0]         occ;
    logic [WID_MEM-1:0] head_data;
    logic               head_last;

    assign head_data = f_data_q[rd_ptr_q];
    assign head_last = f_last_q[rd_ptr_q];

    // Issue only when the FIFO will still have room for this read after this cycle's pop,
    // which keeps one word per cycle flowing when m_ready stays high.
    always_comb begin
        push  = inflight_q;
        pop   = (count_q != 2'd0) && bus.m_ready;
        occ   = count_q + {1'b0, inflight_q} - {1'b0, pop};
        issue = (state_q == ST_SWEEP) && (occ < 2'd2);
    end

    // Sweep control: address counter, read issue, checksum and done pulse.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        raddr_d    = raddr_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        csum_d     = csum_q;
        if (pop) begin
            csum_d = csum_q ^ head_data;
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
            end
            ST_SWEEP: begin
                if (issue) begin
                    raddr_d    = cnt_q;
                    inflight_d = 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            raddr_q    <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            raddr_q    <= raddr_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            csum_q     <= csum_d;
        end
    end

    // Output FIFO: captures the word read in the previous cycle, tagged with its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                f_data_q[i] <= '0;
                f_addr_q[i] <= '0;
                f_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                f_data_q[wr_ptr_q] <= bus.mem_rdata;
                f_addr_q[wr_ptr_q] <= raddr_q;
                f_last_q[wr_ptr_q] <= (raddr_q == LAST_ADDR);
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_raddr = raddr_q;
    assign bus.m_valid   = (count_q != 2'd0);
    assign bus.m_data    = head_data;
    assign bus.m_addr    = f_addr_q[rd_ptr_q];
    assign bus.m_last    = head_last;
    assign bus.checksum  = csum_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Bench for mem_readback_streamer: default-size instance plus a DEPTH_MEM=100 instance.
module tb_mem_readback_streamer;
  localparam int W      = 256;
  localparam int AW     = 7;
  localparam int DEPTH  = 128;
  localparam int DEPTH2 = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs and memory models ----------------
  mem_readback_streamer_if #(.WID_MEM(W), .ADDR_W(AW)) bus ();
  mem_readback_streamer_if #(.WID_MEM(W), .ADDR_W(AW)) bus2 ();

  mem_readback_streamer #(.WID_MEM(W), .DEPTH_MEM(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(rst), .bus(bus));
  mem_readback_streamer #(.WID_MEM(W), .DEPTH_MEM(DEPTH2), .ADDR_W(AW)) dut2 (
    .clk(clk), .reset(rst), .bus(bus2));

  logic [W-1:0] ram  [DEPTH];
  logic [W-1:0] ram2 [DEPTH2];
  assign bus.mem_rdata  = ram[bus.mem_raddr];
  assign bus2.mem_rdata = (int'(bus2.mem_raddr) < DEPTH2) ? ram2[bus2.mem_raddr] : '0;

  logic start_r  = 1'b0;
  logic start2_r = 1'b0;
  logic rdy_r    = 1'b0;
  assign bus.start   = start_r;
  assign bus.m_ready = rdy_r;
  assign bus2.start  = start2_r;
  assign bus2.m_ready = 1'b1;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int j = 0; j < W / 32; j++) v[j*32 +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- m_ready driver ----------------
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random 50%
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy_r = 1'b0;
      2:       rdy_r = 1'($urandom_range(0, 1));
      default: rdy_r = 1'b1;
    endcase
  end

  // ---------------- scoreboard / monitor for main DUT ----------------
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_a_q[$];
  logic [W-1:0]  sw_xor;
  logic [W-1:0]  ed, prev_d;
  logic [AW-1:0] ea, prev_a;
  bit mon_en = 0;
  bit gap_en = 0;
  bit stall_q = 0;
  int hs_cnt = 0, done_cnt = 0, done_cyc = 0, gap_cnt = 0;
  int first_v_rel = -1, start_edge = 0;

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mon_en && !rst) begin
      if (stall_q) begin
        check("stall_valid", W'(bus.m_valid), W'(1));
        check("stall_data", bus.m_data, prev_d);
        check("stall_addr", W'(bus.m_addr), W'(prev_a));
      end
      if (bus.m_valid && first_v_rel < 0) first_v_rel = cyc - start_edge;
      if (gap_en && bus.busy && bus.m_ready && !bus.m_valid) gap_cnt++;
      if (bus.m_valid && bus.m_ready) begin
        check("sb_nonempty", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) begin
          ed = exp_q.pop_front();
          ea = exp_a_q.pop_front();
          sw_xor = sw_xor ^ ed;
          check("m_data", bus.m_data, ed);
          check("m_addr", W'(bus.m_addr), W'(ea));
          check("m_last", W'(bus.m_last), W'(ea == AW'(DEPTH - 1)));
        end
        hs_cnt++;
      end
      stall_q = bus.m_valid && !bus.m_ready;
      prev_d  = bus.m_data;
      prev_a  = bus.m_addr;
    end else begin
      stall_q = 0;
    end
  end

  // ---------------- monitor for DEPTH_MEM=100 DUT ----------------
  int idx2 = 0, max2 = 0, last_addr2 = -1, last_cnt2 = 0, done2_cnt = 0;
  logic [W-1:0] xor2 = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(bus2.mem_raddr) > max2) max2 = int'(bus2.mem_raddr);
      if (bus2.done) done2_cnt++;
      if (bus2.m_valid && bus2.m_ready) begin
        if (idx2 < DEPTH2) begin
          check("d2_data", bus2.m_data, ram2[idx2]);
          check("d2_addr", W'(bus2.m_addr), W'(idx2));
          xor2 = xor2 ^ ram2[idx2];
        end
        if (bus2.m_last) begin
          last_cnt2++;
          last_addr2 = int'(bus2.m_addr);
        end
        idx2++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic queue_sweep();
    exp_q.delete();
    exp_a_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(ram[i]);
      exp_a_q.push_back(AW'(i));
    end
    sw_xor = '0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start_r = 1'b1;
    start_edge  = cyc + 1;
    first_v_rel = -1;
    @(posedge clk);
    #1 start_r = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", W'(done_cnt != prev), W'(1));
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, W'(bus.busy), '0);
    check({pfx, "_done"}, W'(bus.done), '0);
    check({pfx, "_raddr"}, W'(bus.mem_raddr), '0);
    check({pfx, "_valid"}, W'(bus.m_valid), '0);
    check({pfx, "_data"}, bus.m_data, '0);
    check({pfx, "_addr"}, W'(bus.m_addr), '0);
    check({pfx, "_last"}, W'(bus.m_last), '0);
    check({pfx, "_csum"}, bus.checksum, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, n, base, rel_edge;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 check_all_zero("rst");
    @(negedge clk) rst = 1'b0;
    mon_en = 1;

    // A: ram[i]=i, m_ready high
    for (int i = 0; i < DEPTH; i++) ram[i] = W'(i);
    queue_sweep();
    rdy_mode = 1;
    d0 = done_cnt;
    pulse_start();
    wait_done(d0, 400);
    check("a_first_valid", W'(first_v_rel), W'(2));
    check("a_done_lat", W'(done_cyc - start_edge), W'(130));
    check("a_done_cnt", W'(done_cnt), W'(d0 + 1));
    check("a_csum", bus.checksum, W'(0));
    check("a_sb_empty", W'(exp_q.size()), W'(0));
    check("a_busy_after", W'(bus.busy), W'(0));
    check("a_done_pulse", W'(bus.done), W'(0));

    // B: shifted A5 pattern, random back-pressure
    for (int i = 0; i < DEPTH; i++) ram[i] = (W'(8'hA5)) << (i % 8);
    queue_sweep();
    rdy_mode = 2;
    d0 = done_cnt;
    pulse_start();
    wait_done(d0, 3000);
    rdy_mode = 1;
    check("b_csum", bus.checksum, sw_xor);
    check("b_sb_empty", W'(exp_q.size()), W'(0));
    check("b_done_cnt", W'(done_cnt), W'(d0 + 1));

    // C: m_ready low for 20 cycles after start, then released
    for (int i = 0; i < DEPTH; i++) ram[i] = {8{32'(i) + 32'h1000}};
    queue_sweep();
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    d0 = done_cnt;
    pulse_start();
    repeat (20) @(posedge clk);
    #2;
    check("c_raddr", W'(bus.mem_raddr), W'(1));
    check("c_valid", W'(bus.m_valid), W'(1));
    check("c_head_data", bus.m_data, ram[0]);
    check("c_head_addr", W'(bus.m_addr), W'(0));
    check("c_busy", W'(bus.busy), W'(1));
    rdy_mode = 1;
    rel_edge = cyc + 2;
    gap_cnt = 0;
    gap_en = 1;
    wait_done(d0, 400);
    gap_en = 0;
    check("c_gap", W'(gap_cnt), W'(0));
    check("c_done_lat", W'(done_cyc - rel_edge), W'(127));
    check("c_csum", bus.checksum, sw_xor);
    check("c_sb_empty", W'(exp_q.size()), W'(0));

    // D: reset at word 50 aborts the sweep, then a fresh sweep
    for (int i = 0; i < DEPTH; i++) ram[i] = rand_word();
    queue_sweep();
    base = hs_cnt;
    pulse_start();
    n = 0;
    while (hs_cnt < base + 50 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("d_reached_50", W'(hs_cnt >= base + 50), W'(1));
    #2 rst = 1'b1;
    mon_en = 0;
    #1 check_all_zero("abort");
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    check("d_no_done", W'(done_cnt), W'(d0));
    queue_sweep();
    mon_en = 1;
    pulse_start();
    wait_done(d0, 400);
    check("d_first_valid", W'(first_v_rel), W'(2));
    check("d_csum", bus.checksum, sw_xor);
    check("d_sb_empty", W'(exp_q.size()), W'(0));

    // E: a second start during the sweep is ignored
    for (int i = 0; i < DEPTH; i++) ram[i] = rand_word();
    queue_sweep();
    d0 = done_cnt;
    pulse_start();
    repeat (9) @(posedge clk);
    #1 start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    wait_done(d0, 400);
    repeat (20) @(posedge clk);
    check("e_done_cnt", W'(done_cnt), W'(d0 + 1));
    check("e_done_lat", W'(done_cyc - start_edge), W'(130));
    check("e_csum", bus.checksum, sw_xor);
    check("e_sb_empty", W'(exp_q.size()), W'(0));

    // F: DEPTH_MEM=100 instance
    for (int i = 0; i < DEPTH2; i++) ram2[i] = rand_word();
    idx2 = 0; max2 = 0; last_cnt2 = 0; last_addr2 = -1; xor2 = '0;
    d0 = done2_cnt;
    @(posedge clk);
    #1 start2_r = 1'b1;
    @(posedge clk);
    #1 start2_r = 1'b0;
    n = 0;
    while (done2_cnt == d0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #2;
    check("f_done_seen", W'(done2_cnt), W'(d0 + 1));
    check("f_words", W'(idx2), W'(DEPTH2));
    check("f_max_raddr", W'(max2), W'(DEPTH2 - 1));
    check("f_last_addr", W'(last_addr2), W'(DEPTH2 - 1));
    check("f_last_cnt", W'(last_cnt2), W'(1));
    check("f_csum", bus2.checksum, xor2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
